// File: rtl/conv_output_conditioner.sv
// Output conditioner for the convolution engine: round/shift, saturate, wet/dry mix and
// jitter-free per-trigger output with underrun repeat. Optional DC blocker: CONV_OUT_DC_BLOCK_EN.
module conv_output_conditioner #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                        audio_clk,
    input  logic                        rst_n_in,
    input  logic                        audio_trigger,
    input  logic signed [15:0]          dry_audio_in,
    input  logic signed [47:0]          conv_result_in,
    input  logic                        conv_result_valid_in,
    input  logic        [5:0]           shift_in,
    input  logic        [8:0]           wet_level_in,
    output logic signed [15:0]          audio_out,
    output logic                        audio_out_valid,
    output logic                        busy,
    output logic        [CNT_WIDTH-1:0] underrun_count,
    output logic        [CNT_WIDTH-1:0] clip_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCALE, S_SAT, S_MIX, S_DC, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                        vld_prev_q, vld_prev_d;
    logic signed [47:0]          r_q, r_d;
    logic        [5:0]           sh_q, sh_d;
    logic        [8:0]           w_q, w_d;
    logic signed [15:0]          dry_q, dry_d;
    logic signed [15:0]          dry_cap_q, dry_cap_d;
    logic signed [48:0]          s_q, s_d;
    logic signed [15:0]          sat_q, sat_d;
    logic signed [15:0]          mix_q, mix_d;
    logic signed [15:0]          held_q, held_d;
    logic                        ready_q, ready_d;
    logic signed [15:0]          out_q, out_d;
    logic                        out_vld_q, out_vld_d;
    logic        [CNT_WIDTH-1:0] under_q, under_d;
    logic        [CNT_WIDTH-1:0] clip_q, clip_d;
`ifdef CONV_OUT_DC_BLOCK_EN
    logic signed [15:0]          xp_q, xp_d;
    logic signed [23:0]          y_q, y_d;
    logic signed [23:0]          y_calc;
    logic signed [15:0]          y_sat;
`endif

    logic                        vld_edge;
    logic        [5:0]           sh_clamp;
    logic        [8:0]           w_clamp;
    logic signed [48:0]          r_ext, rnd, s_calc;
    logic signed [25:0]          wet_term, dry_term, mix_sum;
    logic        [9:0]           dry_w;

    assign vld_edge = conv_result_valid_in & ~vld_prev_q;
    assign sh_clamp = (shift_in > 6'd47) ? 6'd47 : shift_in;
    assign w_clamp  = (wet_level_in > 9'd256) ? 9'd256 : wet_level_in;

    // Round half up: add half an LSB of the shifted result before the arithmetic shift.
    assign r_ext  = 49'(r_q);
    assign rnd    = (sh_q != 6'd0) ? (49'sd1 <<< (sh_q - 6'd1)) : 49'sd0;
    assign s_calc = (r_ext + rnd) >>> sh_q;

    assign dry_w    = 10'd256 - {1'b0, w_q};
    assign wet_term = $signed({{10{sat_q[15]}}, sat_q}) * $signed({17'd0, w_q});
    assign dry_term = $signed({{10{dry_cap_q[15]}}, dry_cap_q}) * $signed({16'd0, dry_w});
    assign mix_sum  = (wet_term + dry_term + 26'sd128) >>> 8;

`ifdef CONV_OUT_DC_BLOCK_EN
    assign y_calc = {{8{mix_q[15]}}, mix_q} - {{8{xp_q[15]}}, xp_q} + y_q - (y_q >>> 8);
    assign y_sat  = (y_q > 24'sd32767)  ? 16'sh7fff :
                    (y_q < -24'sd32768) ? 16'sh8000 : 16'(y_q);
`endif

    // State register
    always_ff @(posedge audio_clk or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (vld_edge) state_d = S_SCALE;
            S_SCALE: state_d = S_SAT;
            S_SAT:   state_d = S_MIX;
`ifdef CONV_OUT_DC_BLOCK_EN
            S_MIX:   state_d = S_DC;
`else
            S_MIX:   state_d = S_DONE;
`endif
            S_DC:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Datapath and output side
    always_comb begin
        vld_prev_d = conv_result_valid_in;
        r_d        = r_q;
        sh_d       = sh_q;
        w_d        = w_q;
        dry_d      = dry_q;
        dry_cap_d  = dry_cap_q;
        s_d        = s_q;
        sat_d      = sat_q;
        mix_d      = mix_q;
        held_d     = held_q;
        ready_d    = ready_q;
        out_d      = out_q;
        out_vld_d  = audio_trigger;
        under_d    = under_q;
        clip_d     = clip_q;
`ifdef CONV_OUT_DC_BLOCK_EN
        xp_d       = xp_q;
        y_d        = y_q;
`endif

        // The pipeline pairs each result with the dry sample latched before this edge.
        if (state_q == S_IDLE && vld_edge) begin
            r_d       = conv_result_in;
            sh_d      = sh_clamp;
            w_d       = w_clamp;
            dry_cap_d = dry_q;
        end

        case (state_q)
            S_SCALE: s_d = s_calc;
            S_SAT: begin
                if (s_q > 49'sd32767) begin
                    sat_d = 16'sh7fff;
                    if (clip_q != {CNT_WIDTH{1'b1}}) clip_d = clip_q + CNT_WIDTH'(1);
                end else if (s_q < -49'sd32768) begin
                    sat_d = 16'sh8000;
                    if (clip_q != {CNT_WIDTH{1'b1}}) clip_d = clip_q + CNT_WIDTH'(1);
                end else begin
                    sat_d = 16'(s_q);
                end
            end
            S_MIX: mix_d = 16'(mix_sum);
`ifdef CONV_OUT_DC_BLOCK_EN
            S_DC: begin
                y_d  = y_calc;
                xp_d = mix_q;
            end
            S_DONE: held_d = y_sat;
`else
            S_DONE: held_d = mix_q;
`endif
            default: ;
        endcase

        if (audio_trigger) begin
            dry_d = dry_audio_in;
            if (ready_q) begin
                out_d   = held_q;
                ready_d = 1'b0;
            end else if (under_q != {CNT_WIDTH{1'b1}}) begin
                under_d = under_q + CNT_WIDTH'(1);
            end
        end

        // A result finishing in the same cycle as a trigger stays ready for the next one.
        if (state_q == S_DONE) ready_d = 1'b1;
    end

    always_ff @(posedge audio_clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_prev_q <= 1'b0;
            r_q        <= '0;
            sh_q       <= '0;
            w_q        <= '0;
            dry_q      <= '0;
            dry_cap_q  <= '0;
            s_q        <= '0;
            sat_q      <= '0;
            mix_q      <= '0;
            held_q     <= '0;
            ready_q    <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            under_q    <= '0;
            clip_q     <= '0;
`ifdef CONV_OUT_DC_BLOCK_EN
            xp_q       <= '0;
            y_q        <= '0;
`endif
        end else begin
            vld_prev_q <= vld_prev_d;
            r_q        <= r_d;
            sh_q       <= sh_d;
            w_q        <= w_d;
            dry_q      <= dry_d;
            dry_cap_q  <= dry_cap_d;
            s_q        <= s_d;
            sat_q      <= sat_d;
            mix_q      <= mix_d;
            held_q     <= held_d;
            ready_q    <= ready_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            under_q    <= under_d;
            clip_q     <= clip_d;
`ifdef CONV_OUT_DC_BLOCK_EN
            xp_q       <= xp_d;
            y_q        <= y_d;
`endif
        end
    end

    assign audio_out       = out_q;
    assign audio_out_valid = out_vld_q;
    assign underrun_count  = under_q;
    assign clip_count      = clip_q;

endmodule

// File: tb/tb_conv_output_conditioner.sv
// Scoreboard bench for conv_output_conditioner: a transaction-level model pushes the expected
// sample for every trigger; the monitor pops on each audio_out_valid strobe.
module tb_conv_output_conditioner;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               trig;
    logic signed [15:0] dry_in;
    logic signed [47:0] res_in;
    logic               res_vld;
    logic        [5:0]  sh_in;
    logic        [8:0]  w_in;
    logic signed [15:0] audio_out;
    logic               audio_out_valid;
    logic               busy;
    logic        [15:0] underrun_count;
    logic        [15:0] clip_count;

    typedef struct {
        int out;
        int under;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    int m_held, m_ready, m_last, m_under, m_clip, m_dry, m_xp, m_yp;

    always #5 clk = ~clk;

    conv_output_conditioner #(.CNT_WIDTH(16)) dut (
        .audio_clk            (clk),
        .rst_n_in             (rst_n),
        .audio_trigger        (trig),
        .dry_audio_in         (dry_in),
        .conv_result_in       (res_in),
        .conv_result_valid_in (res_vld),
        .shift_in             (sh_in),
        .wet_level_in         (w_in),
        .audio_out            (audio_out),
        .audio_out_valid      (audio_out_valid),
        .busy                 (busy),
        .underrun_count       (underrun_count),
        .clip_count           (clip_count)
    );

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && audio_out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("audio_out", longint'(audio_out), e.out);
                chk("underrun_count", underrun_count, e.under);
            end
        end
    end

    function automatic int clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_reset();
        m_held = 0; m_ready = 0; m_last = 0; m_under = 0;
        m_clip = 0; m_dry = 0; m_xp = 0; m_yp = 0;
    endtask

    task automatic model_trig(input int d);
        exp_t e;
        if (m_ready != 0) begin
            m_last  = m_held;
            m_ready = 0;
        end else begin
            m_under++;
        end
        e.out   = m_last;
        e.under = m_under;
        sb.push_back(e);
        m_dry = d;
    endtask

    task automatic model_result(input longint r, input int sh, input int w);
        longint t;
        int s, m;
        if (sh > 47)  sh = 47;
        if (w > 256)  w = 256;
        t = r + ((sh > 0) ? (64'sd1 << (sh - 1)) : 64'sd0);
        t = t >>> sh;
        s = clamp16(t);
        if (longint'(s) != t && m_clip < 65535) m_clip++;
        m = (s * w + m_dry * (256 - w) + 128) >>> 8;
`ifdef CONV_OUT_DC_BLOCK_EN
        begin
            int y;
            y = m - m_xp + m_yp - (m_yp >>> 8);
            y = (y <<< 8) >>> 8;
            m_xp = m;
            m_yp = y;
            m = clamp16(longint'(y));
        end
`endif
        m_held  = m;
        m_ready = 1;
    endtask

    task automatic do_trig(input int d);
        @(negedge clk);
        model_trig(d);
        trig   = 1'b1;
        dry_in = 16'(d);
        @(negedge clk);
        trig = 1'b0;
        chk("strobe_on", audio_out_valid, 1);
        @(negedge clk);
        chk("strobe_off", audio_out_valid, 0);
    endtask

    task automatic send(input longint r, input int sh, input int w);
        @(negedge clk);
        res_in  = 48'(r);
        sh_in   = 6'(sh);
        w_in    = 9'(w);
        res_vld = 1'b1;
        model_result(r, sh, w);
        @(negedge clk);
        res_vld = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int od, nd;
        model_reset();
        rst_n = 1'b0; trig = 1'b0; dry_in = '0; res_in = '0; res_vld = 1'b0; sh_in = '0; w_in = '0;

        // Reset holds every output at zero regardless of input activity.
        repeat (6) begin
            @(negedge clk);
            trig    = 1'($urandom);
            dry_in  = 16'($urandom);
            res_in  = {16'($urandom), 32'($urandom)};
            res_vld = 1'($urandom);
            sh_in   = 6'($urandom);
            w_in    = 9'($urandom);
        end
        @(negedge clk);
        chk("rst_audio_out", audio_out, 0);
        chk("rst_valid", audio_out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun_count, 0);
        chk("rst_clip", clip_count, 0);
        trig = 1'b0; res_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_trig(0);

        do_trig(1000);
        send(1048576, 8, 256);
        do_trig(0);                                   // 4096
        send(-3, 1, 256);
        do_trig(0);                                   // -1
        send(64'sd1 << 40, 8, 256);
        chk("clip_pos", clip_count, m_clip);
        do_trig(0);                                   // 32767
        send(-(64'sd1 << 40), 8, 256);
        chk("clip_neg", clip_count, m_clip);
        do_trig(-1000);                               // -32768
        send(256000, 8, 128);
        do_trig(500);                                 // 0
        send(12345, 0, 0);
        do_trig(0);                                   // dry 500
        do_trig(0);                                   // underruns repeat previous
        do_trig(0);

        // Overwrite: the later of two results between triggers wins.
        send(100, 0, 256);
        send(200, 0, 256);
        do_trig(0);

        // Edge while busy is ignored.
        @(negedge clk);
        res_in = 48'sd300; sh_in = 6'd0; w_in = 9'd256; res_vld = 1'b1;
        model_result(300, 0, 256);
        @(negedge clk);
        res_vld = 1'b0;
        chk("busy_high", busy, 1);
        @(negedge clk);
        res_in = 48'sd999; res_vld = 1'b1;
        @(negedge clk);
        res_vld = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_low", busy, 0);
        do_trig(7);

        // Shift and wet level clamping.
        send(64'sh7FFF_FFFF_FFFF, 63, 300);
        do_trig(-20);

        // Trigger coinciding with a valid edge: output and capture both proceed.
        send(7000, 0, 256);
        @(negedge clk);
        od = m_dry;
        model_trig(42);
        nd = m_dry;
        m_dry = od;
        model_result(-5000, 0, 128);
        m_dry = nd;
        trig = 1'b1; dry_in = 16'sd42;
        res_in = -48'sd5000; sh_in = 6'd0; w_in = 9'd128; res_vld = 1'b1;
        @(negedge clk);
        trig = 1'b0; res_vld = 1'b0;
        chk("coinc_strobe", audio_out_valid, 1);
        repeat (8) @(negedge clk);
        do_trig(0);

`ifdef CONV_OUT_DC_BLOCK_EN
        repeat (6) begin
            send(256000, 8, 256);
            do_trig(0);
        end
`endif

        // Reset asserted while the pipeline is in SAT discards the result.
        @(negedge clk);
        res_in = 48'sd64000; sh_in = 6'd0; w_in = 9'd256; res_vld = 1'b1;
        @(negedge clk);
        res_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", audio_out_valid, 0);
        chk("midrst_out", audio_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (8) @(negedge clk);
        do_trig(0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        chk("timeout", 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/conv_output_conditioner.md
# conv_output_conditioner

Downstream stage of the convolution engine. Takes each 48-bit convolution result and its completion strobe, scales it with a programmable arithmetic right shift and rounding, and saturates it to 16 bits. It then mixes it with the dry input sample and emits one 16-bit output sample per `audio_trigger` at a fixed, jitter-free point. Results that arrive late are covered by repeating the previous sample and counting the underrun.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of the saturating status counters.

Ports:
- `audio_clk` in 1: single clock for all logic.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `audio_trigger` in 1: one-cycle sample-rate strobe, the same strobe that drives the convolver.
- `dry_audio_in` in 16 signed: dry sample valid while `audio_trigger` is high.
- `conv_result_in` in 48 signed: convolver output; stable while the valid strobe is high.
- `conv_result_valid_in` in 1: convolver completion strobe.
- `shift_in` in 6: right-shift amount; values above 47 clamp to 47.
- `wet_level_in` in 9: wet weight out of 256; values above 256 clamp to 256.
- `audio_out` out 16 signed: conditioned output sample.
- `audio_out_valid` out 1: one-cycle strobe marking each `audio_out` update.
- `busy` out 1: high while a result is in the processing pipeline.
- `underrun_count` out CNT_WIDTH: saturating count of triggers that found no new sample.
- `clip_count` out CNT_WIDTH: saturating count of results clipped at the saturation step.

## Operation
- Reset values: every output is 0. Internal registers reset to 0: held sample, ready flag, latched dry sample, and DC-block state.
- Capture on `audio_trigger`:
  - Latch `dry_audio_in` as the pending dry sample.
  - The result produced for that trigger is mixed with this dry sample.
- Result acceptance:
  - The block acts only on the rising edge of `conv_result_valid_in`, so a level held high counts once.
  - An edge that arrives while `busy` is high is ignored.
- FSM states and transitions:
  - IDLE: on a valid edge, capture `conv_result_in`, `shift_in` and `wet_level_in`, then go to SCALE.
  - SCALE: compute `s = (r + (sh>0 ? 1<<(sh-1) : 0)) >>> sh` in 49 bits (round half up).
  - SAT: clamp `s` to [-32768, 32767]. If clamping occurred, increment `clip_count`, saturating at its maximum.
  - MIX: compute `m = (wet*W + dry*(256-W) + 128) >>> 8` in 26-bit signed arithmetic. The result always fits in 16 bits.
  - DC: present only with the DC-block option (see Configuration).
  - DONE: write the held sample, set the ready flag, return to IDLE.
- `busy` is high in every state except IDLE.
- Output on each `audio_trigger`:
  - If the ready flag is set: `audio_out` becomes the held sample and the ready flag clears.
  - Otherwise: `audio_out` keeps its previous value and `underrun_count` increments, saturating at its maximum.
  - `audio_out_valid` pulses in both cases.
- A second result completing before the next trigger overwrites the held sample; this is not counted.

## Timing
- Valid edge to ready flag:
  - 4 cycles (IDLE capture, SCALE, SAT, MIX, then DONE write) without the DC block.
  - 5 cycles with the DC block.
- `audio_out` and `audio_out_valid` update on the clock edge after the cycle in which `audio_trigger` is high.
- End-to-end latency is one sample period.
- A ready flag set in cycle N is visible to triggers from cycle N+1 onward. A trigger in cycle N itself is an underrun.
- A trigger that coincides with a valid edge is handled independently: output and capture both proceed.
- Reset asserted mid-pipeline: the FSM returns to IDLE immediately and any partial result is discarded. After deassertion, the first trigger reports an underrun with `audio_out` = 0.

## Configuration
- Macro `CONV_OUT_DC_BLOCK_EN`.
- Defined:
  - Adds state DC between MIX and DONE.
  - DC computes `y = x - x_prev + y_prev - (y_prev >>> 8)`, with `y` held in a 24-bit signed register.
  - The output is `y` saturated to 16 bits.
  - `x_prev` and `y_prev` update once per processed result and never on repeated samples.
- Undefined: MIX goes directly to DONE and latency is 4 cycles.

## Test plan
- Reset: hold `rst_n_in` low, apply random inputs -> all outputs 0. Release, then one trigger -> `audio_out` = 0, `audio_out_valid` pulse, `underrun_count` = 1.
- Scaling: `r` = 1048576, `shift` = 8, `W` = 256, `dry` = 1000. Trigger, valid, trigger -> `audio_out` = 4096, strobe exactly 1 cycle after the second trigger.
- Rounding and saturation:
  - `r` = -3, `shift` = 1 -> -1.
  - `r` = 2^40, `shift` = 8 -> 32767, `clip_count` = 1.
  - `r` = -2^40, `shift` = 8 -> -32768, `clip_count` = 2.
- Mix: `W` = 128, wet = 1000, `dry` = -1000 -> 0. `W` = 0 -> `audio_out` equals the dry sample from the paired trigger.
- Underrun and overwrite:
  - Two triggers with no valid -> previous sample repeated twice, `underrun_count` +2.
  - Two valid results between triggers -> the second is emitted.
  - Valid edge while `busy` -> ignored.
- Reset mid-pipeline: assert `rst_n_in` in SAT -> no output update. Next trigger after release -> 0 and an underrun. With `CONV_OUT_DC_BLOCK_EN`, a constant 1000 input decays toward 0 across successive samples.
